// File: rtl/cp0_timer_irq_unit_if.sv
// CP0 timer/interrupt unit bus: software writes, ext lines, and
// the Count/Compare/TI/IP views consumed by the CP0 register file.
interface cp0_timer_irq_unit_if #(
  parameter int NUM_TIMERS    = 1,
  parameter int COUNT_WIDTH   = 32,
  parameter int EXT_IRQ_WIDTH = 6
);
  localparam int SEL_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

  logic                              count_stop;
  logic                              count_we;
  logic [COUNT_WIDTH-1:0]            count_wdata;
  logic                              cmp_we;
  logic [SEL_W-1:0]                  cmp_sel;
  logic [COUNT_WIDTH-1:0]            cmp_wdata;
  logic [NUM_TIMERS-1:0]             ti_en;
  logic [EXT_IRQ_WIDTH-1:0]          ext_int;
  logic [COUNT_WIDTH-1:0]            count;
  logic [NUM_TIMERS*COUNT_WIDTH-1:0] compare;
  logic [NUM_TIMERS-1:0]             ti;
  logic [EXT_IRQ_WIDTH-1:0]          ip;

  modport master (
    output count_stop, count_we, count_wdata,
    output cmp_we, cmp_sel, cmp_wdata,
    output ti_en, ext_int,
    input  count, compare, ti, ip
  );

  modport slave (
    input  count_stop, count_we, count_wdata,
    input  cmp_we, cmp_sel, cmp_wdata,
    input  ti_en, ext_int,
    output count, compare, ti, ip
  );
endinterface

// File: rtl/cp0_timer_irq_unit.sv
// CP0 Count/Compare timer with prescaler, sticky per-channel TI
// flags and synchronised external lines folded into Cause.IP.
module cp0_timer_irq_unit #(
  parameter int NUM_TIMERS    = 1,
  parameter int COUNT_WIDTH   = 32,
  parameter int EXT_IRQ_WIDTH = 6,
  parameter int PRESCALE      = 1,
  parameter int SYNC_STAGES   = 2
) (
  input logic                clk,
  input logic                reset,
  cp0_timer_irq_unit_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]          pre_q, pre_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic [NUM_TIMERS-1:0][COUNT_WIDTH-1:0] cmp_q, cmp_d;
  logic [NUM_TIMERS-1:0]  ti_q, ti_d;
  logic [EXT_IRQ_WIDTH-1:0] ext_s;
  logic                   tick;

  assign tick    = !bus.count_stop && (pre_q == PW'(PRESCALE - 1));
  assign cnt_inc = count_q + 1'b1;

  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    ti_d    = ti_q;
    if (bus.count_we) begin
      pre_d   = '0;
      count_d = bus.count_wdata;
    end else if (tick) begin
      pre_d   = '0;
      count_d = cnt_inc;
    end else if (!bus.count_stop) begin
      pre_d   = pre_q + 1'b1;
    end
    // Match against pre-write compare; a write to the channel wins.
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (tick && !bus.count_we && cnt_inc == cmp_q[k])
        ti_d[k] = 1'b1;
      if (bus.cmp_we && int'(bus.cmp_sel) == k) begin
        cmp_d[k] = bus.cmp_wdata;
        ti_d[k]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      count_q <= '0;
      cmp_q   <= '1;
      ti_q    <= '0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ti_q    <= ti_d;
    end
  end

  if (SYNC_STAGES == 0) begin : g_nosync
    assign ext_s = bus.ext_int;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][EXT_IRQ_WIDTH-1:0] sync_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= bus.ext_int;
        for (int i = 1; i < SYNC_STAGES; i++)
          sync_q[i] <= sync_q[i-1];
      end
    end
    assign ext_s = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    bus.ip = ext_s;
    bus.ip[EXT_IRQ_WIDTH-1] = ext_s[EXT_IRQ_WIDTH-1] | (|(ti_q & bus.ti_en));
  end

  assign bus.count   = count_q;
  assign bus.compare = cmp_q;
  assign bus.ti      = ti_q;
endmodule

// File: tb/tb_cp0_timer_irq_unit.sv
// Bench for cp0_timer_irq_unit: directed scenarios plus random
// traffic, all checked against a cycle-level behavioural model.
module tb_cp0_timer_irq_unit;
  localparam int NT = 3;
  localparam int W  = 32;
  localparam int E  = 6;
  localparam int PRESCALE = 2;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  cp0_timer_irq_unit_if #(.NUM_TIMERS(NT), .COUNT_WIDTH(W),
                          .EXT_IRQ_WIDTH(E)) bus ();

  cp0_timer_irq_unit #(
    .NUM_TIMERS(NT), .COUNT_WIDTH(W), .EXT_IRQ_WIDTH(E),
    .PRESCALE(PRESCALE), .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference state
  logic [W-1:0]  m_cnt;
  int            m_ph;
  logic [W-1:0]  m_cmp [NT];
  logic [NT-1:0] m_ti;
  logic [E-1:0]  m_hist [$];

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0;
    m_ph  = 0;
    for (int k = 0; k < NT; k++) m_cmp[k] = '1;
    m_ti  = '0;
    m_hist = '{6'd0, 6'd0};
  endtask

  task automatic check_all();
    logic [E-1:0] eip;
    eip = m_hist[1];
    eip[E-1] = eip[E-1] | (|(m_ti & bus.ti_en));
    chk("count", 96'(bus.count), 96'(m_cnt));
    chk("compare", 96'(bus.compare), {m_cmp[2], m_cmp[1], m_cmp[0]});
    chk("ti", 96'(bus.ti), 96'(m_ti));
    chk("ip", 96'(bus.ip), 96'(eip));
  endtask

  // one clock: predict from current inputs, clock, then compare
  task automatic step();
    logic [W-1:0]  nc;
    int            np;
    logic [NT-1:0] nt;
    logic [W-1:0]  ncmp [NT];
    logic [E-1:0]  ev;
    bit            tick;
    nc = m_cnt;
    np = m_ph;
    nt = m_ti;
    for (int k = 0; k < NT; k++) ncmp[k] = m_cmp[k];
    ev = bus.ext_int;
    tick = !bus.count_stop && (m_ph == PRESCALE - 1);
    if (bus.count_we) begin
      nc = bus.count_wdata;
      np = 0;
    end else if (tick) begin
      nc = m_cnt + 32'd1;
      np = 0;
      for (int k = 0; k < NT; k++)
        if (nc == m_cmp[k]) nt[k] = 1'b1;
    end else if (!bus.count_stop) begin
      np = m_ph + 1;
    end
    if (bus.cmp_we && bus.cmp_sel < 2'd3) begin
      ncmp[bus.cmp_sel] = bus.cmp_wdata;
      nt[bus.cmp_sel] = 1'b0;
    end
    @(posedge clk);
    m_cnt = nc;
    m_ph  = np;
    m_ti  = nt;
    for (int k = 0; k < NT; k++) m_cmp[k] = ncmp[k];
    m_hist.push_front(ev);
    void'(m_hist.pop_back());
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_count(input logic [W-1:0] v);
    bus.count_we = 1'b1;
    bus.count_wdata = v;
    step();
    bus.count_we = 1'b0;
  endtask

  task automatic wr_cmp(input logic [1:0] sel, input logic [W-1:0] v);
    bus.cmp_we = 1'b1;
    bus.cmp_sel = sel;
    bus.cmp_wdata = v;
    step();
    bus.cmp_we = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] wrap_seq [4];
    reset = 1'b1;
    bus.count_stop = 1'b0;
    bus.count_we = 1'b0;
    bus.count_wdata = '0;
    bus.cmp_we = 1'b0;
    bus.cmp_sel = '0;
    bus.cmp_wdata = '0;
    bus.ti_en = '0;
    bus.ext_int = '0;
    model_reset();
    #2;
    check_all();
    chk("rst_cmp", 96'(bus.compare), {96{1'b1}});
    @(negedge clk);
    reset = 1'b0;

    // basic timer
    bus.ti_en = 3'b001;
    wr_count(32'h10);
    wr_cmp(2'd0, 32'h14);
    idle(7);
    chk("basic_cnt", 96'(bus.count), 96'h14);
    chk("basic_ti", 96'(bus.ti[0]), 96'd1);
    chk("basic_ip5", 96'(bus.ip[5]), 96'd1);
    wr_cmp(2'd0, 32'h20);
    chk("basic_clr", 96'(bus.ti[0]), 96'd0);

    // prescale and wrap
    wr_cmp(2'd0, 32'h0);
    wr_count(32'hFFFF_FFFE);
    chk("wrap_ld", 96'(bus.count), 96'hFFFF_FFFE);
    wrap_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap_seq", 96'(bus.count), 96'(wrap_seq[i]));
    end
    chk("wrap_ti", 96'(bus.ti[0]), 96'd1);

    // multi-channel
    wr_cmp(2'd0, 32'd5);
    wr_cmp(2'd1, 32'd5);
    wr_cmp(2'd2, 32'd9);
    wr_count(32'd0);
    idle(10);
    chk("mc_cnt5", 96'(bus.count), 96'd5);
    chk("mc_ti5", 96'(bus.ti), 96'b011);
    idle(8);
    chk("mc_ti9", 96'(bus.ti), 96'b111);
    bus.ti_en = 3'b100;
    wr_cmp(2'd2, 32'd100);
    chk("mc_ip5", 96'(bus.ip[5]), 96'd0);

    // collision: compare write vs matching tick
    wr_cmp(2'd0, 32'h30);
    wr_cmp(2'd1, 32'h30);
    wr_count(32'h2F);
    step();
    wr_cmp(2'd0, 32'h40);
    chk("col_ti", 96'(bus.ti), 96'b010);
    chk("col_cmp0", 96'(bus.compare[31:0]), 96'h40);
    chk("col_cnt", 96'(bus.count), 96'h30);
    wr_cmp(2'd2, 32'h31);
    wr_count(32'h31);
    chk("cwe_cnt", 96'(bus.count), 96'h31);
    chk("cwe_ti", 96'(bus.ti), 96'b010);
    wr_cmp(2'd3, 32'h55);
    chk("sel_oob", 96'(bus.ti), 96'b010);

    // stop + ext sync
    bus.count_stop = 1'b1;
    held = m_cnt;
    bus.ext_int = 6'b000100;
    step();
    chk("sync_1", 96'(bus.ip[2]), 96'd0);
    step();
    chk("sync_2", 96'(bus.ip[2]), 96'd1);
    bus.ext_int = 6'b0;
    step();
    chk("sync_3", 96'(bus.ip[2]), 96'd1);
    step();
    chk("sync_4", 96'(bus.ip[2]), 96'd0);
    idle(3);
    chk("stop_cnt", 96'(bus.count), 96'(held));
    bus.count_stop = 1'b0;

    // async reset mid-operation
    bus.ti_en = 3'b001;
    wr_cmp(2'd0, 32'h1234);
    wr_count(32'h1233);
    idle(2);
    chk("pre_rst_ti", 96'(bus.ti[0]), 96'd1);
    chk("pre_rst_cnt", 96'(bus.count), 96'h1234);
    async_reset();
    chk("arst_cnt", 96'(bus.count), 96'd0);
    chk("arst_cmp", 96'(bus.compare), {96{1'b1}});
    chk("arst_ti", 96'(bus.ti), 96'd0);
    chk("arst_ip", 96'(bus.ip), 96'd0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.count_stop = ($urandom_range(0, 7) == 0);
      bus.count_we = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0: bus.count_wdata = $urandom();
        1: bus.count_wdata = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: bus.count_wdata = m_cmp[$urandom_range(0, NT-1)];
      endcase
      bus.cmp_we = ($urandom_range(0, 9) == 0);
      bus.cmp_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        bus.cmp_wdata = $urandom_range(0, 3);
      else
        bus.cmp_wdata = m_cnt + 32'($urandom_range(1, 20));
      bus.ti_en = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus.ext_int = 6'($urandom());
      step();
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
